// File: rtl/risc4_pkg.sv
// Shared opcode encoding and decimal-adjust constants for the RISC-4 ALU family.
package risc4_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int DAA_LIMIT = 9;
    localparam int DAA_ADJ   = 6;

    typedef enum logic [ALU_OP_W-1:0] {
        OpAdd  = 4'd0,
        OpAdc  = 4'd1,
        OpSub  = 4'd2,
        OpSbb  = 4'd3,
        OpAnd  = 4'd4,
        OpOr   = 4'd5,
        OpXor  = 4'd6,
        OpSlt  = 4'd7,
        OpSltu = 4'd8,
        OpRal  = 4'd9,
        OpRar  = 4'd10,
        OpDaa  = 4'd11,
        OpMul  = 4'd12
    } alu_op_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, double-width result.
// done is asserted combinationally during the last step; product is valid while done is high.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic               running_q;
    logic [CntW-1:0]    count_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;

    // Add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : {(2 * WIDTH){1'b0}});
    end

    assign done    = running_q && (count_q == CntW'(WIDTH - 1));
    assign product = acc_d;

    // Operand latch on start, then one shift-add step per cycle until the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            count_q   <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, a};
            acc_q     <= '0;
            mplier_q  <= b;
        end else if (running_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered RISC-4 ALU with iterative multiply. Single-cycle ops load
// straight from IDLE; MUL parks the FSM in MUL until the multiplier finishes.
module alu_seq
    import risc4_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_carry,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic [WIDTH-1:0]    out_result_hi,
    output logic                out_carry,
    output logic                out_zero,
    output logic                out_illegal,
    output logic                busy
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StMul  = 1'b1;

    logic [0:0]         state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               carry_q;
    logic               zero_q;
    logic               illegal_q;

    logic               accept;
    logic               mul_start;
    logic               load_alu;
    logic               load_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     cin_ext;
    logic [4:0]         daa_nib;
    logic               daa_fix;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_illegal;

    assign a_ext   = {1'b0, in_a};
    assign b_ext   = {1'b0, in_b};
    assign cin_ext = {{WIDTH{1'b0}}, in_carry};

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (in_op == OpMul);
    assign load_alu  = accept && (in_op != OpMul);
    assign load_mul  = (state_q == StMul) && mul_done;

    assign busy          = (state_q == StMul);
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_result_hi = result_hi_q;
    assign out_carry     = carry_q;
    assign out_zero      = zero_q;
    assign out_illegal   = illegal_q;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; arithmetic carried out in WIDTH+1 bits so bit WIDTH is carry/borrow.
    always_comb begin
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        daa_nib     = {1'b0, in_a[3:0]} + 5'(DAA_ADJ);
        daa_fix     = (in_a[3:0] > 4'(DAA_LIMIT)) || in_carry;
        case (in_op)
            OpAdd:  {alu_carry, alu_res} = a_ext + b_ext;
            OpAdc:  {alu_carry, alu_res} = a_ext + b_ext + cin_ext;
            OpSub:  {alu_carry, alu_res} = a_ext - b_ext;
            OpSbb:  {alu_carry, alu_res} = a_ext - b_ext - cin_ext;
            OpAnd:  alu_res = in_a & in_b;
            OpOr:   alu_res = in_a | in_b;
            OpXor:  alu_res = in_a ^ in_b;
            OpSlt:  alu_res = {{(WIDTH - 1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OpSltu: alu_res = {{(WIDTH - 1){1'b0}}, (in_a < in_b)};
            OpRal:  {alu_carry, alu_res} = {in_a, in_carry};
            OpRar:  {alu_res, alu_carry} = {in_carry, in_a};
            OpDaa: begin
                // Only the low BCD digit is adjusted; upper bits pass through untouched.
                alu_res   = in_a;
                alu_carry = in_carry;
                if (daa_fix) begin
                    alu_res[3:0] = daa_nib[3:0];
                    alu_carry    = in_carry | daa_nib[4];
                end
            end
            OpMul:  alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Control FSM: leave IDLE only for MUL, return when the last step completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (mul_start) begin
            state_q <= StMul;
        end else if (load_mul) begin
            state_q <= StIdle;
        end
    end

    // Result registers: hold while stalled, clear valid on consume unless a new result loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (load_alu) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            result_hi_q <= '0;
            carry_q     <= alu_carry;
            zero_q      <= (alu_res == '0);
            illegal_q   <= alu_illegal;
        end else if (load_mul) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_product[WIDTH-1:0];
            result_hi_q <= mul_product[2*WIDTH-1:WIDTH];
            carry_q     <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            zero_q      <= (mul_product[WIDTH-1:0] == '0);
            illegal_q   <= 1'b0;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a WIDTH=4 and a WIDTH=8 instance share the stimulus
// bus; sel picks which one receives in_valid and whose outputs are observed.
module tb_alu_seq;
    import risc4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       in_valid;
    logic       out_ready;
    logic       in_carry;
    logic [3:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;

    logic       r4_ready, r4_valid, r4_carry, r4_zero, r4_ill, r4_busy;
    logic [3:0] r4_res, r4_hi;
    logic       r8_ready, r8_valid, r8_carry, r8_zero, r8_ill, r8_busy;
    logic [7:0] r8_res, r8_hi;

    logic       o_ready, o_valid, o_carry, o_zero, o_ill, o_busy;
    logic [7:0] o_res, o_hi;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic       carry;
        logic       zero;
        logic       ill;
    } exp_t;

    typedef struct {
        logic       s;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [7:0] hi;
        logic       carry;
        logic       zero;
        logic       ill;
        int         lat;
    } vec_t;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid && !sel),
        .in_ready      (r4_ready),
        .in_op         (in_op),
        .in_a          (in_a[3:0]),
        .in_b          (in_b[3:0]),
        .in_carry      (in_carry),
        .out_valid     (r4_valid),
        .out_ready     (out_ready),
        .out_result    (r4_res),
        .out_result_hi (r4_hi),
        .out_carry     (r4_carry),
        .out_zero      (r4_zero),
        .out_illegal   (r4_ill),
        .busy          (r4_busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid && sel),
        .in_ready      (r8_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_carry      (in_carry),
        .out_valid     (r8_valid),
        .out_ready     (out_ready),
        .out_result    (r8_res),
        .out_result_hi (r8_hi),
        .out_carry     (r8_carry),
        .out_zero      (r8_zero),
        .out_illegal   (r8_ill),
        .busy          (r8_busy)
    );

    always_comb begin
        o_ready = sel ? r8_ready : r4_ready;
        o_valid = sel ? r8_valid : r4_valid;
        o_carry = sel ? r8_carry : r4_carry;
        o_zero  = sel ? r8_zero  : r4_zero;
        o_ill   = sel ? r8_ill   : r4_ill;
        o_busy  = sel ? r8_busy  : r4_busy;
        o_res   = sel ? r8_res   : {4'h0, r4_res};
        o_hi    = sel ? r8_hi    : {4'h0, r4_hi};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour computed with plain integer arithmetic at width w.
    function automatic exp_t model(input longint op, input longint a, input longint b,
                                   input longint cin, input int w);
        longint full;
        longint mask;
        longint r;
        longint hi;
        longint c;
        longint sa;
        longint sb;
        longint lo;
        longint n;
        exp_t   e;
        full = longint'(1) << w;
        mask = full - 1;
        r    = 0;
        hi   = 0;
        c    = 0;
        e.ill = 1'b0;
        case (op)
            0:  begin r = a + b;       c = (r >= full) ? 1 : 0; end
            1:  begin r = a + b + cin; c = (r >= full) ? 1 : 0; end
            2:  begin r = a - b;       c = (r < 0) ? 1 : 0; end
            3:  begin r = a - b - cin; c = (r < 0) ? 1 : 0; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7: begin
                sa = (a >= full / 2) ? a - full : a;
                sb = (b >= full / 2) ? b - full : b;
                r  = (sa < sb) ? 1 : 0;
            end
            8:  r = (a < b) ? 1 : 0;
            9:  begin r = a * 2 + cin; c = (a >= full / 2) ? 1 : 0; end
            10: begin r = (cin != 0 ? full / 2 : 0) + a / 2; c = a % 2; end
            11: begin
                lo = a % 16;
                c  = cin;
                if (lo > 9 || cin != 0) begin
                    n  = lo + 6;
                    c  = (cin != 0 || n > 15) ? 1 : 0;
                    lo = n % 16;
                end
                r = a - (a % 16) + lo;
            end
            12: begin
                r  = (a * b) % full;
                hi = (a * b) / full;
                c  = (hi != 0) ? 1 : 0;
            end
            default: e.ill = 1'b1;
        endcase
        r       = r & mask;
        e.res   = 8'(r);
        e.hi    = 8'(hi);
        e.carry = (c != 0);
        e.zero  = (r == 0);
        return e;
    endfunction

    // Present one request, wait for acceptance, then count edges until the result appears.
    // lat counts clock edges after the accepting edge; busy_n/rdy_n are sampled meanwhile.
    task automatic issue(input logic s, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic c, output exp_t got,
                         output int lat, output int busy_n, output int rdy_n);
        int n;
        n        = 0;
        sel      = s;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_carry = c;
        in_valid = 1'b1;
        #1;
        while (!o_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL issue: in_ready stuck at %0d, required 1", o_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        busy_n   = 0;
        rdy_n    = 0;
        while (!o_valid && lat < 100) begin
            if (o_busy) busy_n++;
            if (o_ready) rdy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        got.res   = o_res;
        got.hi    = o_hi;
        got.carry = o_carry;
        got.zero  = o_zero;
        got.ill   = o_ill;
    endtask

    vec_t vecs[14];

    initial begin
        exp_t       got;
        exp_t       e;
        int         lat;
        int         busy_n;
        int         rdy_n;
        int         w;
        int         seen;
        logic       s;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] ta[11];
        logic [7:0] tb[11];

        //          s     op     a      b      cin   res    hi     c     z     ill  lat
        vecs[0]  = '{1'b0, 4'd0,  8'h9,  8'h8,  1'b1, 8'h1,  8'h0,  1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 4'd1,  8'h9,  8'h8,  1'b1, 8'h2,  8'h0,  1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 4'd3,  8'h3,  8'h3,  1'b1, 8'hF,  8'h0,  1'b1, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 4'd2,  8'h5,  8'h5,  1'b0, 8'h0,  8'h0,  1'b0, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b0, 4'd11, 8'hC,  8'h0,  1'b0, 8'h2,  8'h0,  1'b1, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 4'd11, 8'h5,  8'h0,  1'b1, 8'hB,  8'h0,  1'b1, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 4'd11, 8'h5,  8'h0,  1'b0, 8'h5,  8'h0,  1'b0, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 4'd12, 8'hF,  8'hF,  1'b0, 8'h1,  8'hE,  1'b1, 1'b0, 1'b0, 4};
        vecs[8]  = '{1'b0, 4'd14, 8'h7,  8'h3,  1'b1, 8'h0,  8'h0,  1'b0, 1'b1, 1'b1, 0};
        vecs[9]  = '{1'b1, 4'd9,  8'h81, 8'h0,  1'b0, 8'h02, 8'h0,  1'b1, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b1, 4'd10, 8'h01, 8'h0,  1'b1, 8'h80, 8'h0,  1'b1, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b1, 4'd7,  8'h80, 8'h01, 1'b0, 8'h01, 8'h0,  1'b0, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b1, 4'd8,  8'h80, 8'h01, 1'b0, 8'h00, 8'h0,  1'b0, 1'b1, 1'b0, 0};
        vecs[13] = '{1'b1, 4'd12, 8'h00, 8'h55, 1'b1, 8'h00, 8'h0,  1'b0, 1'b1, 1'b0, 8};

        rst       = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = 4'd0;
        in_a      = 8'h0;
        in_b      = 8'h0;
        in_carry  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset w4", {r4_valid, r4_res, r4_hi, r4_carry, r4_zero, r4_ill, r4_busy, r4_ready},
              32'h1);
        check("reset w8", {r8_valid, r8_res, r8_hi, r8_carry, r8_zero, r8_ill, r8_busy, r8_ready},
              32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table
        foreach (vecs[i]) begin
            issue(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, got, lat, busy_n,
                  rdy_n);
            check($sformatf("vec%0d outputs", i),
                  {got.res, got.hi, got.carry, got.zero, got.ill},
                  {vecs[i].res, vecs[i].hi, vecs[i].carry, vecs[i].zero, vecs[i].ill});
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            if (vecs[i].op == 4'd12) begin
                check($sformatf("vec%0d busy cycles", i), busy_n, vecs[i].lat);
                check($sformatf("vec%0d in_ready while busy", i), rdy_n, 0);
            end
        end

        // Back-to-back ADD stream on W=8, then a 3-cycle consumer stall
        for (int i = 0; i < 11; i++) begin
            ta[i] = 8'($urandom);
            tb[i] = 8'($urandom);
        end
        sel      = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_carry = 1'b1;
        in_a     = ta[0];
        in_b     = tb[0];
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stream in_ready", o_ready, 1);
            @(posedge clk);
            #1;
            e = model(0, ta[i], tb[i], 1, 8);
            check($sformatf("stream %0d", i), {o_valid, o_res, o_carry}, {1'b1, e.res, e.carry});
            in_a = ta[i+1];
            in_b = tb[i+1];
        end
        out_ready = 1'b0;
        e = model(0, ta[9], tb[9], 1, 8);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall in_ready", o_ready, 0);
            check("stall hold", {o_valid, o_res, o_carry}, {1'b1, e.res, e.carry});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("stall release in_ready", o_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model(0, ta[10], tb[10], 1, 8);
        check("post-stall result", {o_valid, o_res, o_carry}, {1'b1, e.res, e.carry});
        @(posedge clk);
        #1;
        check("valid clears on consume", o_valid, 0);

        // Randomised ops on both widths against the model
        for (int i = 0; i < 150; i++) begin
            s  = 1'($urandom);
            w  = s ? 8 : 4;
            op = 4'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            c  = 1'($urandom);
            if (!s) begin
                a[7:4] = 4'h0;
                b[7:4] = 4'h0;
            end
            issue(s, op, a, b, c, got, lat, busy_n, rdy_n);
            e = model(op, a, b, c, w);
            check($sformatf("rand w%0d op%0d a=%0h b=%0h c=%0d", w, op, a, b, c),
                  {got.res, got.hi, got.carry, got.zero, got.ill},
                  {e.res, e.hi, e.carry, e.zero, e.ill});
            check($sformatf("rand w%0d op%0d latency", w, op), lat, (op == 4'd12) ? w : 0);
        end

        // Reset two cycles into a W=8 MUL aborts it
        issue(1'b1, 4'd6, 8'hA5, 8'h0F, 1'b0, got, lat, busy_n, rdy_n);
        sel      = 1'b1;
        in_op    = 4'd12;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mul busy before reset", o_busy, 1);
        rst = 1'b1;
        #1;
        check("async reset clears",
              {o_valid, o_res, o_hi, o_carry, o_zero, o_ill, o_busy}, 32'h0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        check("no result after aborted mul", seen, 0);
        issue(1'b1, 4'd14, 8'h33, 8'h44, 1'b1, got, lat, busy_n, rdy_n);
        check("illegal after reset", {got.res, got.hi, got.carry, got.ill}, {16'h0, 1'b0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
